puzzle_board: RTL and testbench
===============================

# puzzle_board

Board engine for the 3x3 sliding-tile game. It holds the tile configuration and shuffles it with an LFSR when a game starts. It applies player moves and reports back to the game-status FSM. It consumes `game_status` and produces the three handshake signals that FSM samples: `ini_flag` (shuffle done), `active` (legal move made) and `win_flag` (board solved).

## Interface
- `SHUFFLE_MOVES`, 64: legal random moves applied per shuffle; range 1..255.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `clk_d` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `game_status` input 2: 00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED.
- `move_up`, `move_down`, `move_left`, `move_right` input 1 each: debounced single-cycle pulses. Each names the direction the blank moves.
- `board` output 36: cell i (row-major, 0..8) at [4i+3:4i]; value 0 is the blank, 1..8 are tiles.
- `active` output 1: one-cycle pulse per applied player move.
- `ini_flag` output 1: shuffle complete; sticky.
- `win_flag` output 1: board solved after a shuffle.

## Operation
- Solved board: cell i = i+1 for i<8, cell 8 = 0, i.e. `board` = 36'h087654321. `blank_pos` tracks the blank cell index.
- Reset values:
  - `board` = solved, `blank_pos` = 8.
  - `active` = `ini_flag` = `win_flag` = 0.
  - Shuffle count = 0, LFSR = `LFSR_SEED`.
- Move legality, with col = `blank_pos` mod 3:
  - up: `blank_pos` >= 3.
  - down: `blank_pos` <= 5.
  - left: col != 0.
  - right: col != 2.
- Applying a move swaps the blank with the neighbour (`blank_pos` -3/+3/-1/+1) and updates `blank_pos` on the same edge.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances every cycle out of reset, regardless of state.
- CHOSE_BOARD:
  - Board reloads solved and `blank_pos` = 8.
  - `ini_flag`, `win_flag` and shuffle count are cleared.
  - Move inputs are ignored.
- GAME_INITIAL (while `ini_flag` = 0):
  - Each cycle, LFSR[1:0] selects a direction: 00 up, 01 down, 10 left, 11 right.
  - A legal direction is applied and the count increments.
  - An illegal direction is skipped, with no count and no retry in the same cycle.
  - Player moves are ignored and `active` stays 0.
- Shuffle end:
  - When count reaches `SHUFFLE_MOVES` and the board is not solved, `ini_flag` sets on the next edge.
  - If the board is solved at that point, shuffling continues until the first non-solved board, then `ini_flag` sets.
- GAMING:
  - A player move pulse is applied if legal; illegal pulses are dropped silently.
  - Simultaneous pulses resolve by priority up > down > left > right. Only one move is applied per cycle.
  - Moves are accepted whether or not `ini_flag` is set.
- WINNED: board frozen, moves ignored, `win_flag` held.
- `win_flag`:
  - Sets on the edge after a board update leaves the board solved while `ini_flag` = 1.
  - Clears only in CHOSE_BOARD or on reset.
  - A board that is solved while `ini_flag` = 0 never raises it.
- A transition to CHOSE_BOARD from any state, including mid-shuffle, discards progress within one cycle.

## Timing
- Move pulse sampled at edge N: `board`/`blank_pos` update at edge N, and `active` is high for the cycle following edge N.
- `win_flag` rises at edge N+1, so the FSM sees it at edge N+2.
- Shuffle rate: at most one legal move per cycle.
- `ini_flag` rises one edge after the final counted move, or after the first non-solved board if extra moves were needed.
- Shuffle count width: 8 bits. It saturates at `SHUFFLE_MOVES` and never wraps.
- `rst_n` low asynchronously forces all reset values; state holds until the first rising `clk_d` after release.

## Configuration
- `SHUFFLE_NO_BACKTRACK_EN` defined:
  - The shuffler also treats as illegal the exact reverse of its previous shuffle move (up/down, left/right).
  - The previous-move register clears in CHOSE_BOARD and on reset.
- Undefined: only edge legality applies, and immediate reversals are permitted and counted.

## Test plan
- Reset: `rst_n` low, then high -> `board` = 36'h087654321, `active`/`ini_flag`/`win_flag` = 0.
- From reset, `game_status` = 01:
  - `move_up` -> `board` = 36'h687054321, `active` high for exactly 1 cycle.
  - `move_right` -> `board` unchanged, `active` = 0.
- Continue with `move_down` -> board solved, `win_flag` stays 0 because `ini_flag` = 0.
- At `blank_pos` = 8, `move_up` and `move_left` in the same cycle -> only up applied (`blank_pos` = 5), one `active` pulse.
- `SHUFFLE_MOVES` = 4, `game_status` = 10:
  - `ini_flag` rises after 4 legal moves plus any extra needed for a non-solved board.
  - Board is not solved.
  - Then status 01: the bench replays the inverse moves -> `win_flag` = 1 one edge after the last move.
  - Then status 11: moves are ignored.
- Mid-shuffle, drive status 00 -> next edge board solved and `ini_flag` = 0.
  - Separately, assert `rst_n` low mid-shuffle -> immediate reset values.

Source files
------------

// File: rtl/puzzle_board.sv
// Board engine for the 3x3 sliding-tile game: LFSR shuffle, player moves, win detection.
// Optional build macro SHUFFLE_NO_BACKTRACK_EN forbids the shuffler from undoing its previous move.
module puzzle_board #(
  parameter int          SHUFFLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk_d,
  input  logic        rst_n,
  input  logic [1:0]  game_status,
  input  logic        move_up,
  input  logic        move_down,
  input  logic        move_left,
  input  logic        move_right,
  output logic [35:0] board,
  output logic        active,
  output logic        ini_flag,
  output logic        win_flag
);

  typedef enum logic [1:0] {
    CHOSE_BOARD  = 2'b00,
    GAMING       = 2'b01,
    GAME_INITIAL = 2'b10,
    WINNED       = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  localparam logic [8:0][3:0] SOLVED     = 36'h087654321;
  localparam logic [7:0]      SHUF_N     = 8'(SHUFFLE_MOVES);
  localparam logic [15:0]     LFSR_TAPS  = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting Galois

  logic [8:0][3:0] cells;
  logic [3:0]      blank_pos;
  logic [7:0]      shuffle_cnt;
  logic [15:0]     lfsr;

`ifdef SHUFFLE_NO_BACKTRACK_EN
  logic prev_valid;
  dir_e prev_dir;
`endif

  status_e    status;
  logic [1:0] col;
  logic [3:0] legal;
  logic       solved;
  dir_e       shuffle_dir;
  logic       shuffle_ok;
  logic       player_req;
  dir_e       player_dir;
  logic       do_move;
  logic       is_player;
  logic       shuffle_step;
  logic       set_ini;
  dir_e       move_dir;
  logic [3:0] target;

  assign board  = cells;
  assign status = status_e'(game_status);

  // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    col          = 2'd0;
    legal        = '0;
    solved       = (cells == SOLVED);
    shuffle_dir  = dir_e'(lfsr[1:0]);
    shuffle_ok   = 1'b0;
    player_req   = 1'b0;
    player_dir   = DIR_UP;
    do_move      = 1'b0;
    is_player    = 1'b0;
    shuffle_step = 1'b0;
    set_ini      = 1'b0;
    move_dir     = DIR_UP;
    target       = blank_pos;

    case (blank_pos)
      4'd1, 4'd4, 4'd7: col = 2'd1;
      4'd2, 4'd5, 4'd8: col = 2'd2;
      default:          col = 2'd0;
    endcase

    legal[DIR_UP]    = (blank_pos >= 4'd3);
    legal[DIR_DOWN]  = (blank_pos <= 4'd5);
    legal[DIR_LEFT]  = (col != 2'd0);
    legal[DIR_RIGHT] = (col != 2'd2);

    shuffle_ok = legal[shuffle_dir];
`ifdef SHUFFLE_NO_BACKTRACK_EN
    if (prev_valid && (shuffle_dir == dir_e'(prev_dir ^ 2'b01))) shuffle_ok = 1'b0;
`endif

    // Highest-priority pulse wins; a blocked winner is dropped rather than falling through.
    if (move_up) begin
      player_req = 1'b1; player_dir = DIR_UP;
    end else if (move_down) begin
      player_req = 1'b1; player_dir = DIR_DOWN;
    end else if (move_left) begin
      player_req = 1'b1; player_dir = DIR_LEFT;
    end else if (move_right) begin
      player_req = 1'b1; player_dir = DIR_RIGHT;
    end

    case (status)
      GAMING: begin
        if (player_req && legal[player_dir]) begin
          do_move   = 1'b1;
          is_player = 1'b1;
          move_dir  = player_dir;
        end
      end
      GAME_INITIAL: begin
        if (!ini_flag) begin
          if ((shuffle_cnt >= SHUF_N) && !solved) begin
            set_ini = 1'b1;
          end else if (shuffle_ok) begin
            do_move      = 1'b1;
            shuffle_step = 1'b1;
            move_dir     = shuffle_dir;
          end
        end
      end
      default: ;
    endcase

    case (move_dir)
      DIR_UP:    target = blank_pos - 4'd3;
      DIR_DOWN:  target = blank_pos + 4'd3;
      DIR_LEFT:  target = blank_pos - 4'd1;
      DIR_RIGHT: target = blank_pos + 4'd1;
      default:   target = blank_pos;
    endcase
  end

  // NOTE: the cells are nine individual flops rather than a RAM, so they take a full async reset to the solved board.
  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      cells       <= SOLVED;
      blank_pos   <= 4'd8;
      shuffle_cnt <= '0;
      lfsr        <= LFSR_SEED;
      active      <= 1'b0;
      ini_flag    <= 1'b0;
      win_flag    <= 1'b0;
`ifdef SHUFFLE_NO_BACKTRACK_EN
      prev_valid  <= 1'b0;
      prev_dir    <= DIR_UP;
`endif
    end else begin
      // NOTE: non-blocking updates let the swap read both old cell values on the same edge.
      lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      active <= 1'b0;
      if (status == CHOSE_BOARD) begin
        cells       <= SOLVED;
        blank_pos   <= 4'd8;
        shuffle_cnt <= '0;
        ini_flag    <= 1'b0;
        win_flag    <= 1'b0;
`ifdef SHUFFLE_NO_BACKTRACK_EN
        prev_valid  <= 1'b0;
`endif
      end else begin
        if (do_move) begin
          cells[blank_pos] <= cells[target];
          cells[target]    <= 4'd0;
          blank_pos        <= target;
          active           <= is_player;
        end
        if (shuffle_step) begin
          if (shuffle_cnt < SHUF_N) shuffle_cnt <= shuffle_cnt + 8'd1;
`ifdef SHUFFLE_NO_BACKTRACK_EN
          prev_valid <= 1'b1;
          prev_dir   <= move_dir;
`endif
        end
        if (set_ini) ini_flag <= 1'b1;
        // active marks that the previous edge applied a player move; judge the board it left.
        if (active && ini_flag && solved) win_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_puzzle_board.sv
// Self-checking bench for puzzle_board with a cycle-stepped behavioural board model.
// Runs with SHUFFLE_MOVES = 4; honours SHUFFLE_NO_BACKTRACK_EN when defined.
module tb_puzzle_board;

  localparam int N_SHUF = 4;
  localparam logic [35:0] SOLVED_BOARD = 36'h087654321;

  logic        clk_d = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  game_status = 2'b00;
  logic        move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic [35:0] board;
  logic        active, ini_flag, win_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: directions are 0 up, 1 down, 2 left, 3 right (blank movement).
  int        m_cell [9];
  bit [15:0] m_lfsr;
  int        m_count;
  bit        m_active, m_ini, m_win;
  int        m_prev;
  int        shuffle_log [$];

  puzzle_board #(.SHUFFLE_MOVES(N_SHUF), .LFSR_SEED(16'hACE1)) dut (
    .clk_d(clk_d), .rst_n(rst_n), .game_status(game_status),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .board(board), .active(active), .ini_flag(ini_flag), .win_flag(win_flag)
  );

  always #5 clk_d = ~clk_d;

  function automatic void m_solve();
    for (int i = 0; i < 8; i++) m_cell[i] = i + 1;
    m_cell[8] = 0;
  endfunction

  function automatic void m_reset();
    m_solve();
    m_lfsr = 16'hACE1; m_count = 0; m_active = 0; m_ini = 0; m_win = 0; m_prev = -1;
  endfunction

  function automatic int m_blank();
    for (int i = 0; i < 9; i++) if (m_cell[i] == 0) return i;
    return -1;
  endfunction

  function automatic bit m_is_solved();
    for (int i = 0; i < 8; i++) if (m_cell[i] != i + 1) return 0;
    return 1;
  endfunction

  function automatic logic [35:0] m_pack();
    logic [35:0] v = '0;
    for (int i = 0; i < 9; i++) v[4*i +: 4] = 4'(m_cell[i]);
    return v;
  endfunction

  // Neighbour index of the blank in direction d, or -1 when it would leave the grid.
  function automatic int m_neigh(int d);
    int b = m_blank();
    int r = b / 3;
    int c = b % 3;
    case (d)
      0: r = r - 1;
      1: r = r + 1;
      2: c = c - 1;
      default: c = c + 1;
    endcase
    if (r < 0 || r > 2 || c < 0 || c > 2) return -1;
    return r * 3 + c;
  endfunction

  function automatic void m_apply(int d);
    int b = m_blank();
    int n = m_neigh(d);
    m_cell[b] = m_cell[n];
    m_cell[n] = 0;
  endfunction

  // One rising edge of the model, using the inputs currently driven.
  function automatic void model_edge();
    bit [15:0] l = m_lfsr;
    bit was_active = m_active;
    m_lfsr = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    m_active = 0;
    if (game_status == 2'b00) begin
      m_solve(); m_ini = 0; m_win = 0; m_count = 0; m_prev = -1;
      return;
    end
    if (was_active && m_ini && m_is_solved()) m_win = 1;
    if (game_status == 2'b01) begin
      int d = move_up ? 0 : move_down ? 1 : move_left ? 2 : move_right ? 3 : -1;
      if (d >= 0 && m_neigh(d) >= 0) begin
        m_apply(d);
        m_active = 1;
      end
    end else if (game_status == 2'b10 && !m_ini) begin
      if (m_count >= N_SHUF && !m_is_solved()) begin
        m_ini = 1;
      end else begin
        int d = int'(l[1:0]);
        bit ok = (m_neigh(d) >= 0);
`ifdef SHUFFLE_NO_BACKTRACK_EN
        if (m_prev >= 0 && d == (m_prev ^ 1)) ok = 0;
`endif
        if (ok) begin
          m_apply(d);
          if (m_count < N_SHUF) m_count++;
          m_prev = d;
          shuffle_log.push_back(d);
        end
      end
    end
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk_d);
    #1;
  endtask

  task automatic set_moves(input logic [3:0] m);
    {move_up, move_down, move_left, move_right} = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    game_status = 2'b00;
    set_moves(4'b0000);
    m_reset();
    repeat (2) @(posedge clk_d);
    #1;
    n_checks++;
    if (board !== SOLVED_BOARD) begin n_fail++; $display("FAIL reset_board got %h want %h", board, SOLVED_BOARD); end
    n_checks++;
    if ({active, ini_flag, win_flag} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {active, ini_flag, win_flag});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_moves();
    game_status = 2'b01;
    set_moves(4'b1000); tick(); set_moves(4'b0000);
    n_checks++;
    if (board !== 36'h687054321 || active !== 1'b1) begin
      n_fail++; $display("FAIL move_up got %h/%b want 687054321/1", board, active);
    end
    tick();
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL active_one_cycle got %b want 0", active); end
    set_moves(4'b0001); tick(); set_moves(4'b0000);
    n_checks++;
    if (board !== 36'h687054321 || active !== 1'b0) begin
      n_fail++; $display("FAIL illegal_right got %h/%b want 687054321/0", board, active);
    end
    set_moves(4'b0100); tick(); set_moves(4'b0000);
    n_checks++;
    if (board !== SOLVED_BOARD || active !== 1'b1) begin
      n_fail++; $display("FAIL move_down got %h/%b want %h/1", board, active, SOLVED_BOARD);
    end
    repeat (2) tick();
    n_checks++;
    if (win_flag !== 1'b0) begin n_fail++; $display("FAIL win_without_ini got %b want 0", win_flag); end
  endtask

  task automatic test_priority();
    set_moves(4'b1010); tick(); set_moves(4'b0000);
    n_checks++;
    if (board !== 36'h687054321 || active !== 1'b1) begin
      n_fail++; $display("FAIL priority_up_left got %h/%b want 687054321/1", board, active);
    end
    tick();
    n_checks++;
    if (active !== 1'b0) begin n_fail++; $display("FAIL priority_single_pulse got %b want 0", active); end
  endtask

  task automatic test_random_gaming();
    game_status = 2'b01;
    for (int i = 0; i < 120; i++) begin
      int k = int'($urandom_range(0, 5));
      set_moves(k < 4 ? 4'(4'b1000 >> k) : 4'b0000);
      tick();
      set_moves(4'b0000);
      n_checks++;
      if ({board, active, ini_flag, win_flag} !== {m_pack(), m_active, m_ini, m_win}) begin
        n_fail++;
        $display("FAIL random_gaming[%0d] got %h/%b%b%b want %h/%b%b%b", i, board, active, ini_flag,
                 win_flag, m_pack(), m_active, m_ini, m_win);
      end
    end
  endtask

  task automatic test_shuffle_and_win();
    int cycles = 0;
    game_status = 2'b00;
    tick();
    shuffle_log.delete();
    game_status = 2'b10;
    while (cycles < 3000) begin
      tick();
      cycles++;
      if ({board, ini_flag, active} !== {m_pack(), m_ini, 1'b0}) begin
        n_checks++; n_fail++;
        $display("FAIL shuffle_step[%0d] got %h/%b want %h/%b", cycles, board, ini_flag, m_pack(), m_ini);
      end
      if (ini_flag === 1'b1 || m_ini) break;
    end
    n_checks++;
    if (ini_flag !== 1'b1 || !m_ini) begin
      n_fail++; $display("FAIL shuffle_done got %b want 1 after %0d cycles", ini_flag, cycles);
    end
    n_checks++;
    if (board === SOLVED_BOARD || shuffle_log.size() < N_SHUF) begin
      n_fail++; $display("FAIL shuffle_result board %h moves %0d want unsolved and >= %0d", board,
                         shuffle_log.size(), N_SHUF);
    end
    game_status = 2'b01;
    for (int i = shuffle_log.size() - 1; i >= 0; i--) begin
      int d = shuffle_log[i] ^ 1;
      set_moves(4'(4'b1000 >> d));
      tick();
      set_moves(4'b0000);
      n_checks++;
      if ({board, active} !== {m_pack(), 1'b1}) begin
        n_fail++; $display("FAIL replay[%0d] got %h/%b want %h/1", i, board, active, m_pack());
      end
    end
    n_checks++;
    if (board !== SOLVED_BOARD || win_flag !== 1'b0) begin
      n_fail++; $display("FAIL replay_end got %h/%b want %h/0", board, win_flag, SOLVED_BOARD);
    end
    tick();
    n_checks++;
    if (win_flag !== 1'b1 || !m_win) begin n_fail++; $display("FAIL win_rise got %b want 1", win_flag); end
    game_status = 2'b11;
    for (int i = 0; i < 8; i++) begin
      set_moves(4'(4'b1000 >> $urandom_range(0, 3)));
      tick();
      set_moves(4'b0000);
      n_checks++;
      if ({board, active, win_flag} !== {SOLVED_BOARD, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL winned_frozen[%0d] got %h/%b/%b want %h/0/1", i, board, active, win_flag,
                           SOLVED_BOARD);
      end
    end
  endtask

  task automatic test_abort();
    game_status = 2'b00;
    tick();
    game_status = 2'b10;
    repeat (2) tick();
    game_status = 2'b00;
    tick();
    n_checks++;
    if ({board, ini_flag, win_flag} !== {SOLVED_BOARD, 2'b00} || m_pack() !== SOLVED_BOARD) begin
      n_fail++; $display("FAIL abort_chose got %h/%b want %h/0", board, ini_flag, SOLVED_BOARD);
    end
    game_status = 2'b10;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if ({board, active, ini_flag, win_flag} !== {SOLVED_BOARD, 3'b000}) begin
      n_fail++; $display("FAIL async_reset got %h/%b%b%b want %h/000", board, active, ini_flag, win_flag,
                         SOLVED_BOARD);
    end
    @(posedge clk_d);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({board, ini_flag} !== {m_pack(), m_ini}) begin
        n_fail++; $display("FAIL post_reset_shuffle[%0d] got %h/%b want %h/%b", i, board, ini_flag, m_pack(),
                           m_ini);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_moves();
    test_priority();
    test_random_gaming();
    test_shuffle_and_win();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
